// File: rtl/adder_tree_pkg.sv
// Shared sizing helpers for the pipelined adder tree.
package adder_tree_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = 1; v < n; v = v * 2) r++;
    return r;
  endfunction

  function automatic int out_w(input int width, input int num_ops);
    return width + clog2(num_ops);
  endfunction

  // Output width of reduction level l: each level adds one bit of growth.
  function automatic int lvl_w(input int width, input int l);
    return width + l + 1;
  endfunction

endpackage

// File: rtl/adder_tree_level.sv
// One registered pairwise reduction level; the carry-in joins only pair (0, 1).
module adder_tree_level #(
  parameter int N_IN = 8,
  parameter int IN_W = 7
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         advance,
  input  logic                         vld_in,
  input  logic                         acc_in,
  input  logic                         ci,
  input  logic [N_IN*IN_W-1:0]         din,
  output logic                         vld_out,
  output logic                         acc_out,
  output logic [(N_IN/2)*(IN_W+1)-1:0] dout
);

  localparam int OW    = IN_W + 1;
  localparam int N_OUT = N_IN / 2;

  logic [N_OUT*OW-1:0] pair_sum;
  logic [N_OUT*OW-1:0] dat_p0;
  logic                vld_p0;
  logic                acc_p0;

  always_comb begin
    pair_sum = '0;
    for (int k = 0; k < N_OUT; k++) begin
      pair_sum[k*OW +: OW] = OW'(din[(2*k)*IN_W +: IN_W])
                           + OW'(din[(2*k+1)*IN_W +: IN_W])
                           + ((k == 0) ? OW'(ci) : OW'(0));
    end
  end

  // Stage boundary: bubbles shift with data, everything holds on stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0 <= 1'b0;
      acc_p0 <= 1'b0;
    end else if (advance) begin
      vld_p0 <= vld_in;
      acc_p0 <= acc_in;
    end
  end

  always_ff @(posedge clk) begin
    if (advance) dat_p0 <= pair_sum;
  end

  assign vld_out = vld_p0;
  assign acc_out = acc_p0;
  assign dout    = dat_p0;

endmodule

// File: rtl/adder_tree_pipe.sv
// Pipelined NUM_OPS-operand adder tree with carry-in, running accumulation and valid/ready flow.
module adder_tree_pipe
  import adder_tree_pkg::*;
#(
  parameter  int WIDTH   = 7,
  parameter  int NUM_OPS = 8,
  localparam int OUT_W   = out_w(WIDTH, NUM_OPS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_OPS*WIDTH-1:0] ops,
  input  logic                     ci,
  input  logic                     in_acc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OUT_W-1:0]         sum,
  output logic                     acc_ovf
);

  localparam int LEVELS = clog2(NUM_OPS);
  localparam int LAST   = LEVELS - 1;

  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    localparam int IW = WIDTH + l;
    localparam int NI = NUM_OPS >> l;
    localparam int OW = lvl_w(WIDTH, l);

    logic [NI*IW-1:0]     din;
    logic [(NI/2)*OW-1:0] dout;
    logic                 vin, ain, cin, vout, aout;

    if (l == 0) begin : g_head
      assign din = ops;
      assign vin = in_valid;
      assign ain = in_acc;
      assign cin = ci;
    end else begin : g_tail
      assign din = g_lvl[l-1].dout;
      assign vin = g_lvl[l-1].vout;
      assign ain = g_lvl[l-1].aout;
      assign cin = 1'b0;
    end

    adder_tree_level #(.N_IN(NI), .IN_W(IW)) u_level (
      .clk     (clk),
      .rst     (rst),
      .advance (advance),
      .vld_in  (vin),
      .acc_in  (ain),
      .ci      (cin),
      .din     (din),
      .vld_out (vout),
      .acc_out (aout),
      .dout    (dout)
    );
  end

  function automatic logic [OUT_W:0] acc_add(input logic [OUT_W-1:0] a,
                                             input logic [OUT_W-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  logic [OUT_W-1:0] tree_sum;
  logic [OUT_W-1:0] acc;
  logic [OUT_W:0]   acc_nxt;
  logic             tree_vld, tree_acc;

  assign tree_sum = g_lvl[LAST].dout;
  assign tree_vld = g_lvl[LAST].vout;
  assign tree_acc = g_lvl[LAST].aout;
  assign acc_nxt  = acc_add(acc, tree_sum);

  // Output / accumulator stage: acc only moves when a beat lands here.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum       <= '0;
      acc       <= '0;
      acc_ovf   <= 1'b0;
    end else if (advance) begin
      out_valid <= tree_vld;
      if (tree_vld) begin
        if (tree_acc) begin
          sum     <= acc_nxt[OUT_W-1:0];
          acc     <= acc_nxt[OUT_W-1:0];
          acc_ovf <= acc_ovf | acc_nxt[OUT_W];
        end else begin
          sum     <= tree_sum;
          acc     <= tree_sum;
          acc_ovf <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_adder_tree_pipe.sv
// Self-checking bench for adder_tree_pipe: scoreboard model plus directed literal checks.
`timescale 1ns/1ps
module tb_adder_tree_pipe;

  localparam int WIDTH   = 7;
  localparam int NUM_OPS = 8;
  localparam int OUT_W   = 10;
  localparam int OPS_W   = NUM_OPS * WIDTH;
  localparam int LAT     = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst = 1'b1, in_valid = 1'b0, ci = 1'b0, in_acc = 1'b0, out_ready = 1'b1;
  logic             in_ready, out_valid, acc_ovf;
  logic [OPS_W-1:0] ops = '0;
  logic [OUT_W-1:0] sum;

  adder_tree_pipe #(.WIDTH(WIDTH), .NUM_OPS(NUM_OPS)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .ops(ops), .ci(ci),
    .in_acc(in_acc), .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .acc_ovf(acc_ovf)
  );

  logic        rst2 = 1'b1, in_valid2 = 1'b0, ci2 = 1'b0, in_acc2 = 1'b0, out_ready2 = 1'b1;
  logic        in_ready2, out_valid2, acc_ovf2;
  logic [31:0] ops2 = '0;
  logic [16:0] sum2;

  adder_tree_pipe #(.WIDTH(16), .NUM_OPS(2)) dut2 (
    .clk(clk), .rst(rst2), .in_valid(in_valid2), .in_ready(in_ready2), .ops(ops2), .ci(ci2),
    .in_acc(in_acc2), .out_valid(out_valid2), .out_ready(out_ready2), .sum(sum2), .acc_ovf(acc_ovf2)
  );

  int n_chk = 0, n_fail = 0, n_acc = 0;

  typedef struct {
    logic [OUT_W-1:0] s;
    logic             o;
  } exp_t;

  exp_t             q[$];
  logic [OUT_W-1:0] got_s[$];
  logic             got_o[$];
  int unsigned      macc = 0;
  logic             movf = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int unsigned tree_model(input logic [OPS_W-1:0] v, input logic c);
    int unsigned t;
    t = c;
    for (int k = 0; k < NUM_OPS; k++) t += v[k*WIDTH +: WIDTH];
    return t;
  endfunction

  // Scoreboard: inputs are stable at the falling edge, so what is seen here is what the next rising edge acts on.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      macc = 0;
      movf = 1'b0;
    end else begin
      chk("in_ready_rule", in_ready, !out_valid || out_ready);
      if (out_valid) begin
        if (q.size() == 0) chk("spurious_out_valid", out_valid, 0);
        else begin
          chk("sum", sum, q[0].s);
          chk("acc_ovf", acc_ovf, q[0].o);
          if (out_ready) begin
            got_s.push_back(sum);
            got_o.push_back(acc_ovf);
            void'(q.pop_front());
          end
        end
      end
      if (in_valid && in_ready) begin
        int unsigned t;
        n_acc++;
        t = tree_model(ops, ci);
        if (in_acc) begin
          t = macc + t;
          movf = movf | (t >= (1 << OUT_W));
          macc = t % (1 << OUT_W);
        end else begin
          macc = t;
          movf = 1'b0;
        end
        q.push_back('{OUT_W'(macc), movf});
      end
    end
  end

  task automatic send(input logic [WIDTH-1:0] v, input logic c, input logic a);
    int n;
    n = 0;
    in_valid = 1'b1;
    ops      = {NUM_OPS{v}};
    ci       = c;
    in_acc   = a;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("send_timeout", n < 100, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while ((q.size() != 0 || out_valid) && n < 100) begin
      @(posedge clk);
      #1 n++;
    end
    chk("drain_timeout", n < 100, 1);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, base;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    rst2 = 1'b0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_acc_ovf", acc_ovf, 0);
    chk("rst_in_ready", in_ready, 1);

    // Max-value single beat and latency.
    in_valid = 1'b1;
    ops      = {NUM_OPS{7'd127}};
    ci       = 1'b1;
    in_acc   = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    ci  = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1 lat++;
    end
    chk("max_latency", lat, LAT);
    chk("max_sum", sum, 1017);
    drain();

    // Streaming six beats with a three-cycle consumer stall.
    got_s.delete();
    fork
      begin
        for (int i = 1; i <= 6; i++) send(7'(i), 1'b0, 1'b0);
      end
      begin
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
          #3 chk("stall_in_ready", in_ready, 0);
          @(posedge clk);
        end
        #1 out_ready = 1'b1;
      end
    join
    drain();
    chk("stream_count", got_s.size(), 6);
    for (int i = 0; i < 6; i++) chk("stream_sum", got_s[i], 8 * (i + 1));

    // Accumulation with wrap and sticky overflow.
    got_s.delete();
    got_o.delete();
    send(7'd1, 1'b0, 1'b0);
    send(7'd2, 1'b0, 1'b1);
    send(7'd127, 1'b1, 1'b1);
    send(7'd1, 1'b0, 1'b0);
    drain();
    chk("acc_count", got_s.size(), 4);
    chk("acc_a", got_s[0], 8);
    chk("acc_b", got_s[1], 24);
    chk("acc_c", got_s[2], 17);
    chk("acc_c_ovf", got_o[2], 1);
    chk("acc_d", got_s[3], 8);
    chk("acc_d_ovf", got_o[3], 0);

    // Reset mid-flight; overflow set beforehand so its clearing is visible.
    send(7'd127, 1'b1, 1'b1);
    drain();
    chk("pre_rst_ovf", acc_ovf, 1);
    got_s.delete();
    send(7'd127, 1'b1, 1'b1);
    send(7'd127, 1'b1, 1'b1);
    send(7'd127, 1'b1, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_sum", sum, 0);
    chk("midrst_acc_ovf", acc_ovf, 0);
    repeat (8) @(posedge clk);
    #1 chk("midrst_no_stale", got_s.size(), 0);
    send(7'd1, 1'b0, 1'b1);
    drain();
    chk("midrst_count", got_s.size(), 1);
    chk("midrst_acc_from_zero", got_s[0], 8);

    // WIDTH=16, NUM_OPS=2 instance.
    chk("w16_in_ready", in_ready2, 1);
    ops2      = {16'hFFFF, 16'hFFFF};
    ci2       = 1'b1;
    in_valid2 = 1'b1;
    @(posedge clk);
    #1 in_valid2 = 1'b0;
    lat = 1;
    while (!out_valid2 && lat < 20) begin
      @(posedge clk);
      #1 lat++;
    end
    chk("w16_latency", lat, 2);
    chk("w16_sum", sum2, 17'h1FFFF);
    chk("w16_ovf", acc_ovf2, 0);

    // Random traffic with occasional resets.
    base = n_acc;
    for (int cyc = 0; cyc < 60000 && (n_acc - base) < 10000; cyc++) begin
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(4) != 0);
      ops       = OPS_W'({$urandom, $urandom});
      ci        = 1'($urandom_range(1));
      in_acc    = 1'($urandom_range(1));
      rst       = ($urandom_range(1999) == 0);
      @(posedge clk);
      #1;
    end
    rst      = 1'b0;
    in_valid = 1'b0;
    drain();
    chk("random_beats", (n_acc - base) >= 10000, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/adder_tree_pipe.md
# adder_tree_pipe

Parametrised, pipelined successor to the 8-operand carry-save adder tree: sums NUM_OPS unsigned WIDTH-bit operands plus a carry-in through a registered pairwise reduction tree. Results are full precision, and an optional running accumulation spans beats. A valid/ready stream interface lets the block sit between operand producers and downstream datapath consumers with back-pressure.

## Interface
Parameters:
- WIDTH, 7, operand width in bits (>= 1)
- NUM_OPS, 8, operand count; power of two, >= 2
- OUT_W, WIDTH + clog2(NUM_OPS), derived result width; not overridable

Ports:
- clk  in  1  sole clock; all state on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand beat present
- in_ready  out  1  block accepts beat this cycle
- ops  in  NUM_OPS*WIDTH  packed operands; operand k = ops[k*WIDTH +: WIDTH]
- ci  in  1  carry-in, added once per beat
- in_acc  in  1  add this beat's tree sum to the accumulator
- out_valid  out  1  result held on sum
- out_ready  in  1  consumer takes result
- sum  out  OUT_W  result (tree sum, or accumulated value)
- acc_ovf  out  1  sticky: accumulator wrapped since last non-acc beat

## Operation
- Arithmetic: unsigned, zero-extended. Tree sum = sum(ops) + ci, exact in OUT_W bits. The bound is NUM_OPS*(2^WIDTH-1)+1 < 2^OUT_W.
- Level 0 adds operand pairs (2k, 2k+1); ci enters only on the pair (0, 1). Each level grows width by one bit. There are clog2(NUM_OPS) levels, each registered.
- Output stage (registered):
  - in_acc=0: sum <= tree sum; acc <= tree sum; acc_ovf <= 0.
  - in_acc=1: sum <= (acc + tree sum) mod 2^OUT_W; acc <= same value; acc_ovf <= acc_ovf | carry-out.
- in_acc travels down the pipeline with its beat. acc updates only when a beat enters the output register.
- Handshake: advance = !out_valid | out_ready. When advance=1, every stage shifts one step, including bubbles. When advance=0, all stages hold. in_ready = advance, so it is combinational from out_ready/out_valid.
- A beat is accepted when in_valid & in_ready. A result is consumed when out_valid & out_ready. sum and acc_ovf hold stable while out_valid & !out_ready.
- No state machine beyond per-stage valid bits, the data pipeline and the accumulator.

## Timing
- Latency: LAT = clog2(NUM_OPS) + 1 cycles from the accept edge to out_valid, with no stall. Throughput is one beat per cycle.
- Reset (rst=1 at an edge): all stage valids and out_valid 0, sum 0, acc 0, acc_ovf 0. In-flight beats are discarded. in_ready reads 1 from the cycle after reset.
- Reset mid-stream: no partial result is emitted. Accumulation restarts from 0.
- Stall with the pipeline full: no beat is lost or duplicated. A bubble inside the pipeline is not compressed while stalled.
- Simultaneous consume and accept in the same cycle is legal at full rate.
- in_acc=1 on the first beat after reset accumulates onto 0.

## Structure
- Package adder_tree_pkg:
  - clog2 function
  - OUT_W derivation helper
  - level-width function lvl_w(l) = WIDTH + l + 1
- Sub-module adder_tree_level: one reduction level, parametrised by input count and input width. It contains the pairwise adders, data registers, valid and in_acc registers, and hold-on-!advance. It is instantiated clog2(NUM_OPS) times via generate. The output/accumulator stage lives in the top.

## Test plan
WIDTH=7, NUM_OPS=8 (OUT_W=10) unless noted.
- Max-value sum: all ops=127, ci=1, in_acc=0, single beat. Expect sum=1017 and out_valid exactly 4 cycles after accept.
- Streaming with stall: 6 back-to-back beats with ops all = i, ci=0, for i=1..6. Hold out_ready=0 for 3 cycles mid-stream. Expect sums 8,16,24,32,40,48 in order, in_ready=0 during the stall, and no loss.
- Accumulate:
  - beat A: ops all 1, acc=0 → sum 8
  - beat B: ops all 2, acc=1 → sum 24
  - beat C: ops all 127, ci=1, acc=1 → sum 17 (1041 mod 1024), acc_ovf=1
  - beat D: acc=0 clears acc_ovf
- Reset mid-flight: accept 3 beats, then assert rst for 1 cycle. Expect out_valid=0, sum=0, acc_ovf=0, no stale result afterwards, and a following in_acc=1 beat of all 1s gives 8.
- Reparametrised, WIDTH=16, NUM_OPS=2 (OUT_W=17): ops 0xFFFF, 0xFFFF, ci=1 → sum 0x1FFFF with latency 2.
- Random: 10k beats with random valid/ready and in_acc, checked against a scoreboard model computing mod-2^OUT_W sums and sticky acc_ovf.
